// File: rtl/servo_pkg.sv
// Shared constants, FSM state type and pulse classification helpers for the
// servo PWM decoder.
package servo_pkg;

  localparam int unsigned CNT_W  = 20;
  localparam int unsigned DIFF_W = 21;

  localparam int unsigned CLK_HZ_DEF     = 24_000_000;
  localparam int unsigned PERIOD_NOM_DEF = 480_000;
  localparam int unsigned W0_NOM_DEF     = 12_000;
  localparam int unsigned W1_NOM_DEF     = 36_000;
  localparam int unsigned TOL_DEF        = 1_200;
  localparam int unsigned TIMEOUT_DEF    = 960_000;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [1:0] POS_0       = 2'd0;
  localparam logic [1:0] POS_1       = 2'd1;
  localparam logic [1:0] POS_INVALID = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_e;

  // |v - nom| <= tol, evaluated in 21-bit signed so nothing can overflow
  function automatic logic within_tol(input logic [CNT_W-1:0] v,
                                      input int unsigned      nom,
                                      input int unsigned      tol);
    logic signed [DIFF_W-1:0] diff;
    logic        [DIFF_W-1:0] mag;
    diff = $signed({1'b0, v}) - $signed(DIFF_W'(nom));
    mag  = diff[DIFF_W-1] ? $unsigned(-diff) : $unsigned(diff);
    return mag <= DIFF_W'(tol);
  endfunction

  // Frame period is checked first: an off-rate frame is never a valid position
  function automatic logic [1:0] classify(input logic [CNT_W-1:0] w,
                                          input logic [CNT_W-1:0] p,
                                          input int unsigned      w0_nom,
                                          input int unsigned      w1_nom,
                                          input int unsigned      tol,
                                          input int unsigned      period_nom);
    if (!within_tol(p, period_nom, period_nom / 20)) return POS_INVALID;
    if (within_tol(w, w0_nom, tol))                  return POS_0;
    if (within_tol(w, w1_nom, tol))                  return POS_1;
    return POS_INVALID;
  endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer plus delay flop with rise/fall detection.
// A rise is only reported once the synchronized input has been seen low
// after reset, so a line already high at reset release is not a rise.
module sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       s3_q, s3_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;

  // Next-state for the shift chain, pipeline-fill counter and arm flag
  always_comb begin
    s1_d    = din;
    s2_d    = s1_q;
    s3_d    = s2_q;
    fill_d  = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
    // s2 only reflects the real input once two samples have shifted in
    armed_d = armed_q | ((fill_q == 2'd2) & ~s2_q);
  end

  // Register stage, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      fill_q  <= '0;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign level = s2_q;
  assign rise  = armed_q & s2_q & ~s3_q;
  assign fall  = ~s2_q & s3_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// Servo PWM decoder: measures high time and rise-to-rise period of a servo
// pulse train, classifies the pulse into a position and flags signal loss.
module servo_pwm_decoder
  import servo_pkg::*;
#(
  parameter int unsigned CLK_HZ     = CLK_HZ_DEF,
  parameter int unsigned PERIOD_NOM = PERIOD_NOM_DEF,
  parameter int unsigned W0_NOM     = W0_NOM_DEF,
  parameter int unsigned W1_NOM     = W1_NOM_DEF,
  parameter int unsigned TOL        = TOL_DEF,
  parameter int unsigned TIMEOUT    = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic [1:0]       position,
  output logic             valid,
  output logic             signal_lost
);

  // Counters are 20 bits wide and a frame must be shorter than one second
  if ((TIMEOUT >= (1 << CNT_W)) || (PERIOD_NOM > CLK_HZ)) begin : g_bad_params
    $error("servo_pwm_decoder: parameter set out of range");
  end

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  logic level_unused;
  logic rise, fall;

  sync_edge u_sync_edge (
    .clk   (clk),
    .rst   (rst),
    .din   (pwm_in),
    .level (level_unused),
    .rise  (rise),
    .fall  (fall)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] width_cap_q, width_cap_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [1:0]       position_q, position_d;
  logic             valid_q, valid_d;
  logic             lost_q, lost_d;
  logic             timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= TIMEOUT_C) ? v : v + CNT_ONE;
  endfunction

  assign timeout = (period_cnt_q >= TIMEOUT_C);

  // Frame FSM: counts high time and period, publishes a frame on each rise
  // that closes a complete high/low pair
  always_comb begin
    state_d      = state_q;
    width_cnt_d  = width_cnt_q;
    period_cnt_d = period_cnt_q;
    width_cap_d  = width_cap_q;
    width_d      = width_q;
    period_d     = period_q;
    position_d   = position_q;
    valid_d      = 1'b0;
    lost_d       = lost_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d      = HIGH;
          width_cnt_d  = CNT_ONE;
          period_cnt_d = CNT_ONE;
        end
      end
      HIGH: begin
        if (timeout) begin
          state_d    = IDLE;
          lost_d     = 1'b1;
          position_d = POS_INVALID;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
          if (fall) begin
            width_cap_d = width_cnt_q;
            state_d     = LOW;
          end else begin
            width_cnt_d = sat_inc(width_cnt_q);
          end
        end
      end
      LOW: begin
        if (timeout) begin
          state_d    = IDLE;
          lost_d     = 1'b1;
          position_d = POS_INVALID;
        end else if (rise) begin
          width_d      = width_cap_q;
          period_d     = period_cnt_q;
          position_d   = classify(width_cap_q, period_cnt_q,
                                  W0_NOM, W1_NOM, TOL, PERIOD_NOM);
          valid_d      = 1'b1;
          lost_d       = 1'b0;
          width_cnt_d  = CNT_ONE;
          period_cnt_d = CNT_ONE;
          state_d      = HIGH;
        end else begin
          period_cnt_d = sat_inc(period_cnt_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      width_cnt_q  <= '0;
      period_cnt_q <= '0;
      width_cap_q  <= '0;
      width_q      <= '0;
      period_q     <= '0;
      position_q   <= POS_INVALID;
      valid_q      <= 1'b0;
      lost_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      width_cnt_q  <= width_cnt_d;
      period_cnt_q <= period_cnt_d;
      width_cap_q  <= width_cap_d;
      width_q      <= width_d;
      period_q     <= period_d;
      position_q   <= position_d;
      valid_q      <= valid_d;
      lost_q       <= lost_d;
    end
  end

  assign width       = width_q;
  assign period      = period_q;
  assign position    = position_q;
  assign valid       = valid_q;
  assign signal_lost = lost_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Self-checking bench for servo_pwm_decoder with scaled-down timing.
module tb_servo_pwm_decoder;

  localparam int CLK_HZ = 100_000;
  localparam int PNOM   = 1000;
  localparam int W0     = 25;
  localparam int W1     = 75;
  localparam int TOLV   = 3;
  localparam int TMO    = 2000;
  localparam int TCK    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pwm_in = 1'b0;
  logic [19:0] width;
  logic [19:0] period;
  logic [1:0]  position;
  logic        valid;
  logic        signal_lost;

  always #5 clk = ~clk;

  servo_pwm_decoder #(
    .CLK_HZ     (CLK_HZ),
    .PERIOD_NOM (PNOM),
    .W0_NOM     (W0),
    .W1_NOM     (W1),
    .TOL        (TOLV),
    .TIMEOUT    (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .pwm_in      (pwm_in),
    .width       (width),
    .period      (period),
    .position    (position),
    .valid       (valid),
    .signal_lost (signal_lost)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: frames as driven, classified from the rules directly
  typedef struct {
    int  w;
    int  p;
    int  pos;
    time t;
  } frame_t;

  frame_t exp_q[$];
  int     prev_w = 0;
  int     prev_p = 0;
  bit     have_prev = 1'b0;
  int     npushed = 0;
  int     nvalid = 0;
  int     held_w = 0;
  int     held_p = 0;

  function automatic int absdiff(input int a, input int b);
    return (a > b) ? a - b : b - a;
  endfunction

  function automatic int ref_pos(input int w, input int p);
    if (absdiff(p, PNOM) > PNOM / 20) return 3;
    if (absdiff(w, W0) <= TOLV)       return 0;
    if (absdiff(w, W1) <= TOLV)       return 1;
    return 3;
  endfunction

  // A rise closes the previous frame, unless that frame timed out
  task automatic note_rise(input int h, input int l);
    if (have_prev && prev_p < TMO) begin
      exp_q.push_back('{prev_w, prev_p, ref_pos(prev_w, prev_p), $time});
      npushed++;
      held_w = prev_w;
      held_p = prev_p;
    end
    have_prev = 1'b1;
    prev_w    = h;
    prev_p    = h + l;
  endtask

  task automatic drive_frame(input int h, input int l);
    note_rise(h, l);
    pwm_in = 1'b1;
    repeat (h) @(negedge clk);
    pwm_in = 1'b0;
    repeat (l) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_width"},    int'(width),       0);
    check_val({tag, "_period"},   int'(period),      0);
    check_val({tag, "_position"}, int'(position),    3);
    check_val({tag, "_valid"},    int'(valid),       0);
    check_val({tag, "_lost"},     int'(signal_lost), 1);
  endtask

  // Valid monitor: each strobe must match the oldest expected frame
  initial begin
    forever begin
      frame_t e;
      @(negedge clk);
      if (valid === 1'b1) begin
        nvalid++;
        if (exp_q.size() == 0) begin
          check_val("spurious_valid", int'(valid), 0);
        end else begin
          e = exp_q.pop_front();
          check_val("frame_width",    int'(width),       e.w);
          check_val("frame_period",   int'(period),      e.p);
          check_val("frame_position", int'(position),    e.pos);
          check_val("frame_lost",     int'(signal_lost), 0);
          check_val("valid_latency",  int'(($time - e.t) / TCK), 3);
        end
      end
    end
  end

  initial begin
    #(TCK * 90000);
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Three 0.5 ms-equivalent frames give two valids
    repeat (3) drive_frame(W0, PNOM - W0);
    check_val("valids_3_frames", nvalid, npushed);
    check_val("w0_width",    int'(width),    W0);
    check_val("w0_period",   int'(period),   PNOM);
    check_val("w0_position", int'(position), 0);

    // Switch to 1.5 ms, then tolerance edges around W1
    drive_frame(W1, PNOM - W1);
    drive_frame(W1, PNOM - W1);
    drive_frame(W1 + TOLV, PNOM - W1 - TOLV);
    drive_frame(W1 + TOLV + 1, PNOM - W1 - TOLV - 1);
    drive_frame(W0 - TOLV, PNOM - W0 + TOLV);
    drive_frame(W0, PNOM - W0 + PNOM / 20);

    // Randomized widths and periods straddling the tolerance windows
    for (int i = 0; i < 12; i++) begin
      int kind;
      int h;
      int p;
      kind = int'($urandom_range(0, 2));
      case (kind)
        0:       h = W0 + int'($urandom_range(0, 10)) - 5;
        1:       h = W1 + int'($urandom_range(0, 10)) - 5;
        default: h = int'($urandom_range(10, 200));
      endcase
      p = PNOM + int'($urandom_range(0, 140)) - 70;
      drive_frame(h, p - h);
    end

    // Stuck-low loss and recovery
    drive_frame(W0, PNOM - W0);
    drive_frame(W0, TMO + 1000);
    check_val("low_to_pending",  exp_q.size(),      0);
    check_val("low_to_lost",     int'(signal_lost), 1);
    check_val("low_to_position", int'(position),    3);
    check_val("low_to_width",    int'(width),       held_w);
    check_val("low_to_period",   int'(period),      held_p);
    drive_frame(W1, PNOM - W1);
    check_val("recover_first_lost", int'(signal_lost), 1);
    drive_frame(W1, PNOM - W1);
    check_val("recover_second_lost", int'(signal_lost), 0);

    // Stuck-high loss, then an off-rate frame
    drive_frame(TMO + 1000, 500);
    check_val("high_to_lost",     int'(signal_lost), 1);
    check_val("high_to_position", int'(position),    3);
    check_val("high_to_width",    int'(width),       held_w);
    check_val("high_to_period",   int'(period),      held_p);
    drive_frame(W0, 833 - W0);
    drive_frame(W0, 833 - W0);
    drive_frame(W0, PNOM - W0);
    check_val("offrate_position", int'(position), 3);

    // Reset during the high time with the input still high afterwards
    note_rise(W0, 0);
    pwm_in = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("midpulse_reset");
    rst       = 1'b0;
    have_prev = 1'b0;
    repeat (50) @(negedge clk);
    pwm_in = 1'b0;
    repeat (900) @(negedge clk);
    check_val("post_reset_width", int'(width), 0);
    drive_frame(W0, PNOM - W0);
    check_val("post_reset_first_width", int'(width),       0);
    check_val("post_reset_first_lost",  int'(signal_lost), 1);
    drive_frame(W1, PNOM - W1);
    drive_frame(W0, PNOM - W0);
    repeat (20) @(negedge clk);

    check_val("pending_at_end", exp_q.size(), 0);
    check_val("valid_total",    nvalid,       npushed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
